// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_port_arbiter_pkg;

    localparam int unsigned ADDR_W   = 26;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned BE_W     = 2;
    localparam int unsigned WAIT_W   = 16;
    localparam int unsigned STARVE_W = 4;

    // Read data returned to a port whose transaction timed out
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID,
        ST_HOST,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byte_enable;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] write_data;
    } bus_cmd_t;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Arbitrates a video read port and a host read/write port onto one SDRAM bridge,
// with bounded host starvation and a per-transaction acknowledge timeout.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned HOST_STARVE = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] vid_address,
    input  logic              vid_read,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_read_data,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [BE_W-1:0]   host_byte_enable,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [DATA_W-1:0] host_write_data,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_read_data,
    output logic [ADDR_W-1:0] bus_address,
    output logic [BE_W-1:0]   bus_byte_enable,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_write_data,
    input  logic              bus_acknowledge,
    input  logic [DATA_W-1:0] bus_read_data,
    output logic              timeout_err
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(HOST_STARVE);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    state_t                state;
    bus_cmd_t              cmd;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [WAIT_W-1:0]     wait_cnt;

    logic                  host_req_c;
    logic                  host_grant_c;
    logic                  done_c;
    logic [DATA_W-1:0]     resp_data_c;

    // Host wins when video is idle or when video has had its quota of grants
    assign host_req_c   = host_read | host_write;
    assign host_grant_c = host_req_c && (!vid_read || (starve_cnt == STARVE_MAX));
    // Acknowledge takes precedence over a coincident timeout
    assign done_c       = bus_acknowledge || (wait_cnt == WAIT_LAST);
    assign resp_data_c  = bus_acknowledge ? bus_read_data : TIMEOUT_DATA;

    assign bus_address     = cmd.address;
    assign bus_byte_enable = cmd.byte_enable;
    assign bus_read        = cmd.read;
    assign bus_write       = cmd.write;
    assign bus_write_data  = cmd.write_data;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state          <= ST_IDLE;
            cmd            <= '0;
            starve_cnt     <= '0;
            wait_cnt       <= '0;
            vid_ack        <= 1'b0;
            host_ack       <= 1'b0;
            vid_read_data  <= '0;
            host_read_data <= '0;
            timeout_err    <= 1'b0;
        end else begin
            vid_ack  <= 1'b0;
            host_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (host_grant_c) begin
                        state            <= ST_HOST;
                        starve_cnt       <= '0;
                        cmd.address      <= host_address;
                        cmd.byte_enable  <= host_byte_enable;
                        cmd.write        <= host_write;
                        cmd.read         <= ~host_write;
                        cmd.write_data   <= host_write_data;
                    end else if (vid_read) begin
                        state            <= ST_VID;
                        if (!host_req_c)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        cmd.address      <= vid_address;
                        cmd.byte_enable  <= '1;
                        cmd.write        <= 1'b0;
                        cmd.read         <= 1'b1;
                        cmd.write_data   <= '0;
                    end
                end
                ST_VID, ST_HOST: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (done_c) begin
                        state <= ST_DONE;
                        cmd   <= '0;
                        if (!bus_acknowledge)
                            timeout_err <= 1'b1;
                        if (state == ST_VID) begin
                            vid_ack       <= 1'b1;
                            vid_read_data <= resp_data_c;
                        end else begin
                            host_ack       <= 1'b1;
                            host_read_data <= resp_data_c;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_sdram_port_arbiter;

    localparam int unsigned TMO    = 8;
    localparam int unsigned STARVE = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [25:0] vid_address;
    logic        vid_read;
    logic        vid_ack;
    logic [15:0] vid_read_data;
    logic [25:0] host_address;
    logic [1:0]  host_byte_enable;
    logic        host_read;
    logic        host_write;
    logic [15:0] host_write_data;
    logic        host_ack;
    logic [15:0] host_read_data;
    logic [25:0] bus_address;
    logic [1:0]  bus_byte_enable;
    logic        bus_read;
    logic        bus_write;
    logic [15:0] bus_write_data;
    logic        bus_acknowledge;
    logic [15:0] bus_read_data;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    sdram_port_arbiter #(.TIMEOUT(TMO), .HOST_STARVE(STARVE)) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .vid_address      (vid_address),
        .vid_read         (vid_read),
        .vid_ack          (vid_ack),
        .vid_read_data    (vid_read_data),
        .host_address     (host_address),
        .host_byte_enable (host_byte_enable),
        .host_read        (host_read),
        .host_write       (host_write),
        .host_write_data  (host_write_data),
        .host_ack         (host_ack),
        .host_read_data   (host_read_data),
        .bus_address      (bus_address),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read         (bus_read),
        .bus_write        (bus_write),
        .bus_write_data   (bus_write_data),
        .bus_acknowledge  (bus_acknowledge),
        .bus_read_data    (bus_read_data),
        .timeout_err      (timeout_err)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic clear_inputs();
        vid_address      = '0;
        vid_read         = 1'b0;
        host_address     = '0;
        host_byte_enable = '0;
        host_read        = 1'b0;
        host_write       = 1'b0;
        host_write_data  = '0;
        bus_acknowledge  = 1'b0;
        bus_read_data    = '0;
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset_reset = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_read || bus_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        clear_inputs();
        step();
        step();
        checks++;
        if ({bus_read, bus_write, vid_ack, host_ack, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus_read, bus_write, vid_ack, host_ack, timeout_err});
        end
        checks++;
        if ({bus_address, bus_byte_enable, bus_write_data} !== 44'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h be=%b wd=%h required all 0",
                     bus_address, bus_byte_enable, bus_write_data);
        end
        checks++;
        if ({vid_read_data, host_read_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: vid=%h host=%h required 0", vid_read_data, host_read_data);
        end
        reset_reset = 1'b0;
    endtask

    task automatic test_ack_ignored();
        bus_acknowledge = 1'b1;
        bus_read_data   = 16'h7777;
        repeat (3) begin
            step();
            checks++;
            if ({vid_ack, host_ack, vid_read_data, host_read_data} !== 34'h0) begin
                errors++;
                $display("FAIL ack_in_idle: acks=%b vid=%h host=%h required 0",
                         {vid_ack, host_ack}, vid_read_data, host_read_data);
            end
        end
        bus_acknowledge = 1'b0;
        bus_read_data   = '0;
    endtask

    task automatic test_video_read();
        bit ok;
        vid_address = 26'h0ABCDE;
        vid_read    = 1'b1;
        wait_grant(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vid_grant: no grant within bound");
        end
        checks++;
        if ({bus_read, bus_write, bus_byte_enable, bus_address} !== {4'b1011, 26'h0ABCDE}) begin
            errors++;
            $display("FAIL vid_cmd: rd=%b wr=%b be=%b addr=%h required 1 0 11 0abcde",
                     bus_read, bus_write, bus_byte_enable, bus_address);
        end
        repeat (2) begin
            step();
            checks++;
            if (bus_read !== 1'b1 || vid_ack !== 1'b0) begin
                errors++;
                $display("FAIL vid_wait: rd=%b ack=%b required 1 0", bus_read, vid_ack);
            end
        end
        bus_acknowledge = 1'b1;
        bus_read_data   = 16'h1234;
        step();
        bus_acknowledge = 1'b0;
        bus_read_data   = '0;
        vid_read        = 1'b0;
        checks++;
        if ({vid_ack, host_ack, bus_read, vid_read_data} !== {3'b100, 16'h1234}) begin
            errors++;
            $display("FAIL vid_done: vack=%b hack=%b rd=%b data=%h required 1 0 0 1234",
                     vid_ack, host_ack, bus_read, vid_read_data);
        end
        step();
        checks++;
        if (vid_ack !== 1'b0 || vid_read_data !== 16'h1234) begin
            errors++;
            $display("FAIL vid_pulse: ack=%b data=%h required 0 1234", vid_ack, vid_read_data);
        end
    endtask

    task automatic test_host_write();
        bit ok;
        host_address     = 26'h0000100;
        host_write_data  = 16'hBEEF;
        host_byte_enable = 2'b01;
        host_write       = 1'b1;
        host_read        = 1'b1;
        wait_grant(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL host_grant: no grant within bound");
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bus_read, bus_write, bus_byte_enable, bus_address, bus_write_data} !==
                {4'b0101, 26'h0000100, 16'hBEEF}) begin
                errors++;
                $display("FAIL host_cmd_stable[%0d]: rd=%b wr=%b be=%b addr=%h wd=%h", k,
                         bus_read, bus_write, bus_byte_enable, bus_address, bus_write_data);
            end
            if (k < 3) step();
        end
        bus_acknowledge = 1'b1;
        bus_read_data   = 16'h5555;
        step();
        bus_acknowledge = 1'b0;
        host_write      = 1'b0;
        host_read       = 1'b0;
        checks++;
        if ({host_ack, vid_ack, bus_write, bus_read, host_read_data} !== {4'b1000, 16'h5555}) begin
            errors++;
            $display("FAIL host_done: hack=%b vack=%b wr=%b rd=%b data=%h required 1 0 0 0 5555",
                     host_ack, vid_ack, bus_write, bus_read, host_read_data);
        end
        step();
        checks++;
        if (host_ack !== 1'b0 || vid_read_data !== 16'h1234) begin
            errors++;
            $display("FAIL host_pulse: hack=%b vid_data=%h required 0 1234", host_ack, vid_read_data);
        end
    endtask

    task automatic test_starvation();
        bit ok;
        do_reset();
        vid_address     = 26'h0000040;
        host_address    = 26'h2000000;
        host_write_data = 16'h0F0F;
        vid_read        = 1'b1;
        host_write      = 1'b1;
        for (int n = 0; n < 10; n++) begin
            wait_grant(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL starve_grant[%0d]: no grant within bound", n);
                break;
            end
            if (bus_write !== ((n % 5) == 4)) begin
                errors++;
                $display("FAIL starve_order[%0d]: got %s required %s", n,
                         bus_write ? "H" : "V", ((n % 5) == 4) ? "H" : "V");
            end
            bus_acknowledge = 1'b1;
            step();
            bus_acknowledge = 1'b0;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        host_address = 26'h1234567;
        host_read    = 1'b1;
        wait_grant(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_grant: no grant within bound");
        end
        for (int k = 1; k <= int'(TMO); k++) begin
            checks++;
            if (bus_read !== 1'b1 || host_ack !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait[%0d]: rd=%b ack=%b required 1 0", k, bus_read, host_ack);
            end
            step();
        end
        host_read = 1'b0;
        checks++;
        if ({bus_read, host_ack, timeout_err, host_read_data} !== {3'b011, 16'hFFFF}) begin
            errors++;
            $display("FAIL tmo_done: rd=%b ack=%b err=%b data=%h required 0 1 1 ffff",
                     bus_read, host_ack, timeout_err, host_read_data);
        end
        repeat (3) step();
        checks++;
        if (timeout_err !== 1'b1 || host_ack !== 1'b0) begin
            errors++;
            $display("FAIL tmo_sticky: err=%b ack=%b required 1 0", timeout_err, host_ack);
        end
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: err=%b required 0", timeout_err);
        end
    endtask

    task automatic test_coincide();
        bit ok;
        do_reset();
        vid_address = 26'h0000333;
        vid_read    = 1'b1;
        wait_grant(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coin_grant: no grant within bound");
        end
        repeat (TMO - 1) step();
        bus_acknowledge = 1'b1;
        bus_read_data   = 16'hA5C3;
        step();
        bus_acknowledge = 1'b0;
        vid_read        = 1'b0;
        checks++;
        if ({vid_ack, timeout_err, vid_read_data} !== {2'b10, 16'hA5C3}) begin
            errors++;
            $display("FAIL coin_done: ack=%b err=%b data=%h required 1 0 a5c3",
                     vid_ack, timeout_err, vid_read_data);
        end
        step();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL coin_err: err=%b required 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        host_address = 26'h0ABCABC;
        host_read    = 1'b1;
        wait_grant(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmid_grant: no grant within bound");
        end
        step();
        step();
        reset_reset = 1'b1;
        host_read   = 1'b0;
        step();
        checks++;
        if ({bus_read, bus_write, bus_address, bus_byte_enable, bus_write_data,
             vid_ack, host_ack, timeout_err, vid_read_data, host_read_data} !== 82'h0) begin
            errors++;
            $display("FAIL rmid_outputs: rd=%b addr=%h hack=%b err=%b required all 0",
                     bus_read, bus_address, host_ack, timeout_err);
        end
        reset_reset     = 1'b0;
        bus_acknowledge = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (host_ack !== 1'b0 || bus_read !== 1'b0) begin
                errors++;
                $display("FAIL rmid_noack: hack=%b rd=%b required 0 0", host_ack, bus_read);
            end
        end
        bus_acknowledge = 1'b0;
    endtask

    // Transaction-level model: each grant is predicted from who is pending and how
    // many video grants the host has already waited through.
    task automatic test_random(input int n);
        bit          vp, hp, hw, ok, win_host, done, exp_terr;
        logic [25:0] va, ha, exp_addr;
        logic [1:0]  hbe, exp_be;
        logic [15:0] hwd, rd, exp_data, got_data;
        int          streak, d, k, exp_k;
        logic [45:0] grant_cmd;
        vp = 0; hp = 0; hw = 0; exp_terr = 0; streak = 0;
        va = '0; ha = '0; hbe = '0; hwd = '0;
        do_reset();
        for (int t = 0; t < n; t++) begin
            if (!vp && $urandom_range(0, 2) != 0) begin
                vp = 1; va = {1'b0, 25'($urandom)};
            end
            if (!hp && $urandom_range(0, 2) != 0) begin
                hp = 1; ha = {1'b1, 25'($urandom)}; hw = 1'($urandom);
                hbe = 2'($urandom); hwd = 16'($urandom);
            end
            if (!vp && !hp) begin
                vp = 1; va = {1'b0, 25'($urandom)};
            end
            vid_read         = vp;
            vid_address      = va;
            host_write       = hp & hw;
            host_read        = hp & (~hw | 1'($urandom));
            host_address     = ha;
            host_byte_enable = hbe;
            host_write_data  = hwd;

            win_host = hp && (!vp || streak == int'(STARVE));
            if (win_host)  streak = 0;
            else if (!hp)  streak = 0;
            else if (streak < int'(STARVE)) streak++;

            wait_grant(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: no grant within bound", t);
                break;
            end
            exp_addr = win_host ? ha : va;
            exp_be   = win_host ? hbe : 2'b11;
            checks++;
            if ({bus_address, bus_byte_enable, bus_read, bus_write} !==
                {exp_addr, exp_be, win_host ? ~hw : 1'b1, win_host ? hw : 1'b0}) begin
                errors++;
                $display("FAIL rnd_cmd[%0d]: addr=%h be=%b rd=%b wr=%b required %h %b %b %b", t,
                         bus_address, bus_byte_enable, bus_read, bus_write, exp_addr, exp_be,
                         win_host ? ~hw : 1'b1, win_host ? hw : 1'b0);
            end
            if (win_host && hw) begin
                checks++;
                if (bus_write_data !== hwd) begin
                    errors++;
                    $display("FAIL rnd_wdata[%0d]: got %h required %h", t, bus_write_data, hwd);
                end
            end
            grant_cmd = {bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data};

            d     = int'($urandom_range(0, 9));
            rd    = 16'($urandom);
            exp_k = (d + 1 <= int'(TMO)) ? d + 1 : int'(TMO);
            exp_data = (d + 1 <= int'(TMO)) ? rd : 16'hFFFF;
            if (d + 1 > int'(TMO)) exp_terr = 1;
            k = 0; done = 0;
            while (!done && k < 12) begin
                k++;
                if ({bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data} !== grant_cmd) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_stable[%0d]: command changed before completion", t);
                end
                bus_acknowledge = (k == d + 1);
                bus_read_data   = rd;
                step();
                done = vid_ack | host_ack;
            end
            bus_acknowledge = 1'b0;
            checks++;
            if (k !== exp_k) begin
                errors++;
                $display("FAIL rnd_latency[%0d]: got %0d cycles required %0d", t, k, exp_k);
            end
            checks++;
            if ({vid_ack, host_ack} !== (win_host ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rnd_ackport[%0d]: got %b required %b", t, {vid_ack, host_ack},
                         win_host ? 2'b01 : 2'b10);
            end
            got_data = win_host ? host_read_data : vid_read_data;
            checks++;
            if (got_data !== exp_data) begin
                errors++;
                $display("FAIL rnd_rdata[%0d]: got %h required %h", t, got_data, exp_data);
            end
            checks++;
            if (timeout_err !== exp_terr) begin
                errors++;
                $display("FAIL rnd_terr[%0d]: got %b required %b", t, timeout_err, exp_terr);
            end
            if (win_host) hp = 0;
            else          vp = 0;
        end
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        clear_inputs();
        reset_reset = 1'b1;
        test_reset();
        test_ack_ignored();
        test_video_read();
        test_host_write();
        test_starvation();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_random(60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
